gpu_ucode_sequencer: RTL and testbench
======================================

// Module: gpu_ucode_sequencer
// PURPOSE
// - Microcode program counter/sequencer for the GPU; drives gpu_ucode_rom address, receives fetched uop back.
// - Resolves gjz/gjnz/ggoto branches against the datapath zero flag; stalls on grvmem until VRAM read completes.
// - Marks which fetched uop the datapath executes each cycle; flags the frame restart jump.
// PARAMETERS
// - ADDR_W        8              uop address width (ROM depth 2^ADDR_W)
// - UOP_SZ        `GPU_UOP_SZ    uop width
// - OP_W          5              opcode field width, opcode = iUop[UOP_SZ-1 -: OP_W]
// - OP_JZ         `gjz           jump if zero opcode
// - OP_JNZ        `gjnz          jump if not zero opcode
// - OP_GOTO       `ggoto         unconditional jump opcode
// - OP_RVMEM      `grvmem        VRAM read opcode (multi-cycle)
// - PC_LAST       100            last populated ROM address
// - RESTART_ADDR  2              jump target that begins a new frame
// PORTS
// - iClock         in   1            clock
// - iReset         in   1            synchronous, active-high reset
// - iEnable        in   1            LCD/GPU enable; low forces IDLE
// - iUop           in   UOP_SZ       uop from gpu_ucode_rom (combinational of oUopAddr)
// - iZero          in   1            datapath zero flag from last executed ALU uop
// - iVmemAck       in   1            VRAM read data valid in vmem_data
// - oUopAddr       out  ADDR_W       ROM address = PC register
// - oUopValid      out  1            datapath executes iUop this cycle
// - oVmemReq       out  1            VRAM read request, held until ack
// - oFrameRestart  out  1            1-cycle pulse when a jump to RESTART_ADDR is taken
// BEHAVIOUR
// - Reset (sync, priority over all): PC=0, state IDLE, oUopValid=0, oVmemReq=0, oFrameRestart=0.
// - States: IDLE, RUN, WAIT_VMEM. Outputs registered except oUopValid (= state==RUN).
// - IDLE: PC held 0; iEnable=1 -> RUN next cycle at PC=0 (always a nop).
// - RUN: iUop decoded same cycle; next PC:
//   - OP_GOTO -> target; OP_JZ & iZero -> target; OP_JNZ & !iZero -> target; untaken -> PC+1.
//   - target = iUop[ADDR_W-1:0] (low bits of 18-bit jump field); upper field bits ignored.
//   - OP_RVMEM -> PC held, oVmemReq=1 next cycle, state WAIT_VMEM.
//   - other opcodes -> PC+1.
// - WAIT_VMEM: oUopValid=0 (grvmem not re-executed), oVmemReq held 1; iVmemAck=1 -> oVmemReq=0,
//   PC+1, RUN next cycle. Ack ignored outside WAIT_VMEM. Min grvmem latency: 2 cycles (ack in first wait cycle).
// - Next PC > PC_LAST (fall-through or jump) -> PC=0; ADDR_W arithmetic wraps 2^ADDR_W-1 -> 0 likewise.
// - oFrameRestart=1 for one cycle after any taken jump whose target == RESTART_ADDR.
// - iEnable=0 in any state -> IDLE next cycle, PC=0, oVmemReq dropped, pending read abandoned.
// - iZero sampled only on the jump cycle; flag stability is datapath's responsibility.
// TESTING
// - Reset then iEnable=1: oUopAddr 0,1,2,3... one step/cycle; oUopValid=0 in IDLE, 1 from first RUN cycle.
// - PC=19 with OP_JZ target 54, iZero=1 -> next oUopAddr=54; iZero=0 -> 20. OP_JNZ at 93 target 6: iZero=0 -> 6.
// - OP_RVMEM at PC=7, ack after 3 wait cycles -> oVmemReq high 3 cycles, oUopAddr stays 7, oUopValid 1 then 0,0,0, then PC=8.
// - OP_GOTO target 2 at PC=89 -> oUopAddr=2, oFrameRestart pulses exactly once; untaken gjz to 2 -> no pulse.
// - PC=100 (PC_LAST) non-jump -> next oUopAddr=0; jump target 200 -> 0.
// - iEnable dropped mid WAIT_VMEM -> oVmemReq=0, PC=0, IDLE next cycle; iReset mid-RUN -> PC=0 next cycle.

Source files
------------

// File: rtl/gpu_ucode_sequencer.sv
// Microcode program counter / sequencer for the GPU.
// Addresses the uop ROM, resolves branches against the datapath zero flag,
// stalls on VRAM reads and flags the jump that starts a new frame.
module gpu_ucode_sequencer #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned UOP_SZ       = 24,
  parameter int unsigned OP_W         = 5,
  parameter int unsigned OP_JZ        = 9,
  parameter int unsigned OP_JNZ       = 10,
  parameter int unsigned OP_GOTO      = 8,
  parameter int unsigned OP_RVMEM     = 3,
  parameter int unsigned PC_LAST      = 100,
  parameter int unsigned RESTART_ADDR = 2
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic [UOP_SZ-1:0] iUop,
  input  logic              iZero,
  input  logic              iVmemAck,
  output logic [ADDR_W-1:0] oUopAddr,
  output logic              oUopValid,
  output logic              oVmemReq,
  output logic              oFrameRestart
);

  localparam logic [OP_W-1:0]   OP_JZ_C    = OP_W'(OP_JZ);
  localparam logic [OP_W-1:0]   OP_JNZ_C   = OP_W'(OP_JNZ);
  localparam logic [OP_W-1:0]   OP_GOTO_C  = OP_W'(OP_GOTO);
  localparam logic [OP_W-1:0]   OP_RVMEM_C = OP_W'(OP_RVMEM);
  localparam logic [ADDR_W-1:0] PC_LAST_C  = ADDR_W'(PC_LAST);
  localparam logic [ADDR_W-1:0] RESTART_C  = ADDR_W'(RESTART_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              vmem_req_q, vmem_req_d;
  logic              frame_restart_q, frame_restart_d;

  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic              is_rvmem;
  logic              jump_taken;
  logic              unused_uop_bits;

  // Addresses past the populated ROM region restart the program at 0.
  function automatic logic [ADDR_W-1:0] limit_pc(input logic [ADDR_W-1:0] pc);
    return (pc > PC_LAST_C) ? '0 : pc;
  endfunction

  // Uop decode: opcode field, jump target and branch resolution.
  always_comb begin
    opcode     = iUop[UOP_SZ-1 -: OP_W];
    target     = iUop[ADDR_W-1:0];
    is_rvmem   = (opcode == OP_RVMEM_C);
    jump_taken = (opcode == OP_GOTO_C) ||
                 ((opcode == OP_JZ_C)  &&  iZero) ||
                 ((opcode == OP_JNZ_C) && !iZero);
    pc_inc     = limit_pc(pc_q + ADDR_W'(1));
  end

  // Upper jump-field bits carry no meaning for the sequencer.
  assign unused_uop_bits = ^iUop[UOP_SZ-OP_W-1:ADDR_W];

  // State register and registered outputs.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q         <= S_IDLE;
      pc_q            <= '0;
      vmem_req_q      <= 1'b0;
      frame_restart_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      vmem_req_q      <= vmem_req_d;
      frame_restart_q <= frame_restart_d;
    end
  end

  // Next-state logic; losing enable always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iEnable)  state_d = S_RUN;
      S_RUN:   if (is_rvmem) state_d = S_WAIT;
      S_WAIT:  if (iVmemAck) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (!iEnable) state_d = S_IDLE;
  end

  // PC, VRAM request and frame-restart next values; uop valid in RUN only.
  always_comb begin
    pc_d            = pc_q;
    vmem_req_d      = 1'b0;
    frame_restart_d = 1'b0;
    oUopValid       = (state_q == S_RUN);
    case (state_q)
      S_IDLE: pc_d = '0;
      S_RUN: begin
        if (is_rvmem) begin
          vmem_req_d = 1'b1;
        end else if (jump_taken) begin
          pc_d            = limit_pc(target);
          frame_restart_d = (target == RESTART_C);
        end else begin
          pc_d = pc_inc;
        end
      end
      S_WAIT: begin
        if (iVmemAck) pc_d = pc_inc;
        else          vmem_req_d = 1'b1;
      end
      default: pc_d = '0;
    endcase
    if (!iEnable) begin
      pc_d            = '0;
      vmem_req_d      = 1'b0;
      frame_restart_d = 1'b0;
    end
  end

  assign oUopAddr      = pc_q;
  assign oVmemReq      = vmem_req_q;
  assign oFrameRestart = frame_restart_q;

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Self-checking bench for gpu_ucode_sequencer: directed branch/stall/wrap
// scenarios followed by randomized ROM contents and inputs against a model.
module tb_gpu_ucode_sequencer;

  localparam int unsigned AW    = 8;
  localparam int unsigned US    = 24;
  localparam int unsigned OW    = 5;
  localparam int unsigned JZ    = 9;
  localparam int unsigned JNZ   = 10;
  localparam int unsigned GOTO  = 8;
  localparam int unsigned RVMEM = 3;
  localparam int unsigned LAST  = 100;
  localparam int unsigned RST_A = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;

  logic          iClock = 1'b0;
  logic          iReset = 1'b1;
  logic          iEnable = 1'b0;
  logic [US-1:0] iUop;
  logic          iZero = 1'b0;
  logic          iVmemAck = 1'b0;
  logic [AW-1:0] oUopAddr;
  logic          oUopValid;
  logic          oVmemReq;
  logic          oFrameRestart;

  logic [US-1:0] rom [256];

  int tests = 0;
  int fails = 0;

  int m_state = M_IDLE;
  int m_pc    = 0;
  bit m_req   = 1'b0;
  bit m_rs    = 1'b0;

  gpu_ucode_sequencer #(
    .ADDR_W(AW), .UOP_SZ(US), .OP_W(OW), .OP_JZ(JZ), .OP_JNZ(JNZ),
    .OP_GOTO(GOTO), .OP_RVMEM(RVMEM), .PC_LAST(LAST), .RESTART_ADDR(RST_A)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iUop(iUop),
    .iZero(iZero), .iVmemAck(iVmemAck), .oUopAddr(oUopAddr),
    .oUopValid(oUopValid), .oVmemReq(oVmemReq), .oFrameRestart(oFrameRestart)
  );

  always #5 iClock = ~iClock;

  assign iUop = rom[oUopAddr];

  function automatic logic [US-1:0] mk(input int op, input int fld);
    return US'((op << 19) | (fld & 32'h3FFFF));
  endfunction

  function automatic int wrap_pc(input int p);
    return (p > int'(LAST)) ? 0 : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: one clock of sequencer behaviour given this cycle's inputs.
  task automatic model_step(input bit rst, input bit en, input bit z, input bit ack);
    int uop, op, tgt;
    bit taken;
    m_rs = 1'b0;
    if (rst || !en) begin
      m_state = M_IDLE; m_pc = 0; m_req = 1'b0;
    end else if (m_state == M_IDLE) begin
      m_state = M_RUN; m_pc = 0; m_req = 1'b0;
    end else if (m_state == M_RUN) begin
      uop   = int'(rom[m_pc]);
      op    = uop >> 19;
      tgt   = uop % 256;
      taken = (op == int'(GOTO)) || (op == int'(JZ) && z) || (op == int'(JNZ) && !z);
      if (op == int'(RVMEM)) begin
        m_state = M_WAIT; m_req = 1'b1;
      end else if (taken) begin
        m_pc = wrap_pc(tgt);
        m_rs = (tgt == int'(RST_A));
      end else begin
        m_pc = wrap_pc(m_pc + 1);
      end
    end else begin
      if (ack) begin
        m_state = M_RUN; m_pc = wrap_pc(m_pc + 1); m_req = 1'b0;
      end else begin
        m_req = 1'b1;
      end
    end
  endtask

  // Apply inputs for one cycle, advance the model, then compare at negedge.
  task automatic drive(input bit rst, input bit en, input bit z, input bit ack);
    iReset = rst; iEnable = en; iZero = z; iVmemAck = ack;
    model_step(rst, en, z, ack);
    @(posedge iClock);
    @(negedge iClock);
    chk("addr",    32'(oUopAddr),     32'(m_pc));
    chk("valid",   32'(oUopValid),    32'(m_state == M_RUN));
    chk("vreq",    32'(oVmemReq),     32'(m_req));
    chk("restart", 32'(oFrameRestart), 32'(m_rs));
  endtask

  initial begin
    int r;
    int fld;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[3]  = mk(GOTO, 19);
    rom[19] = mk(JZ, 54);
    rom[54] = mk(GOTO, 19);
    rom[20] = mk(GOTO, 93);
    rom[93] = mk(JNZ, 32'h3FF00 | 6);
    rom[7]  = mk(RVMEM, 0);
    rom[8]  = mk(GOTO, 89);
    rom[89] = mk(GOTO, 2);

    @(negedge iClock);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("rst_addr", 32'(oUopAddr), 0);
    chk("rst_valid", 32'(oUopValid), 0);
    chk("rst_vreq", 32'(oVmemReq), 0);
    drive(0, 1, 0, 0);
    chk("run_first_addr", 32'(oUopAddr), 0);
    chk("run_first_valid", 32'(oUopValid), 1);
    drive(0, 1, 0, 0); chk("step1", 32'(oUopAddr), 1);
    drive(0, 1, 0, 0); chk("step2", 32'(oUopAddr), 2);
    drive(0, 1, 0, 0); chk("step3", 32'(oUopAddr), 3);
    drive(0, 1, 0, 0); chk("goto19", 32'(oUopAddr), 19);
    drive(0, 1, 1, 0); chk("jz_taken", 32'(oUopAddr), 54);
    drive(0, 1, 0, 0); chk("back19", 32'(oUopAddr), 19);
    drive(0, 1, 0, 0); chk("jz_untaken", 32'(oUopAddr), 20);
    drive(0, 1, 0, 0); chk("goto93", 32'(oUopAddr), 93);
    drive(0, 1, 0, 0); chk("jnz_taken", 32'(oUopAddr), 6);
    drive(0, 1, 0, 0); chk("at7_valid", 32'(oUopValid), 1);
    drive(0, 1, 0, 1);
    chk("wait1_addr", 32'(oUopAddr), 7);
    chk("wait1_valid", 32'(oUopValid), 0);
    chk("wait1_vreq", 32'(oVmemReq), 1);
    drive(0, 1, 0, 0); chk("wait2_vreq", 32'(oVmemReq), 1);
    drive(0, 1, 0, 0); chk("wait3_vreq", 32'(oVmemReq), 1);
    drive(0, 1, 0, 1);
    chk("ack_addr", 32'(oUopAddr), 8);
    chk("ack_vreq", 32'(oVmemReq), 0);
    drive(0, 1, 0, 0); chk("goto89_rs", 32'(oFrameRestart), 0);
    drive(0, 1, 0, 0);
    chk("restart_addr", 32'(oUopAddr), 2);
    chk("restart_pulse", 32'(oFrameRestart), 1);
    drive(0, 1, 0, 0); chk("restart_once", 32'(oFrameRestart), 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0); chk("wait_again", 32'(oVmemReq), 1);
    drive(0, 0, 0, 0);
    chk("disable_vreq", 32'(oVmemReq), 0);
    chk("disable_addr", 32'(oUopAddr), 0);
    chk("disable_valid", 32'(oUopValid), 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    chk("midrun_rst_addr", 32'(oUopAddr), 0);
    chk("midrun_rst_valid", 32'(oUopValid), 0);

    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[1]   = mk(JZ, 2);
    rom[2]   = mk(JNZ, 200);
    rom[3]   = mk(GOTO, 100);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("jz_untaken_to2_addr", 32'(oUopAddr), 2);
    chk("jz_untaken_to2_rs", 32'(oFrameRestart), 0);
    drive(0, 1, 1, 0);
    drive(0, 1, 0, 0); chk("goto100", 32'(oUopAddr), 100);
    drive(0, 1, 0, 0); chk("last_wrap", 32'(oUopAddr), 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0); chk("jump200_wrap", 32'(oUopAddr), 0);

    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 9));
      fld = int'($urandom & 32'h3FF00) |
            (($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 140)));
      case (r)
        0, 1:    rom[i] = mk(GOTO, fld);
        2, 3:    rom[i] = mk(JZ, fld);
        4, 5:    rom[i] = mk(JNZ, fld);
        6:       rom[i] = mk(RVMEM, fld);
        default: rom[i] = mk(int'($urandom_range(0, 31)), fld);
      endcase
    end
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 97,
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
